// File: rtl/fft_pkg.sv
// Shared types, sizes and index helpers for the FFT input buffer.
package fft_pkg;
    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned LINE_W           = 512;
    localparam int unsigned SAMPLES_PER_LINE = LINE_W / SAMPLE_W;
    localparam int unsigned NUM_LINES        = 64;
    localparam int unsigned FFT_N            = SAMPLES_PER_LINE * NUM_LINES;
    localparam int unsigned LINE_IDX_W       = $clog2(NUM_LINES);
    localparam int unsigned SMP_IDX_W        = $clog2(FFT_N);
    localparam int unsigned LANE_W           = $clog2(SAMPLES_PER_LINE);
    localparam int unsigned LANE_SHIFT       = $clog2(SAMPLE_W);

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [LINE_W-1:0]     line_t;
    typedef logic [LINE_IDX_W-1:0] line_idx_t;
    typedef logic [SMP_IDX_W-1:0]  smp_idx_t;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic smp_idx_t bitrev11(input smp_idx_t idx);
        smp_idx_t rev;
        rev = '0;
        for (int unsigned b = 0; b < SMP_IDX_W; b++) begin
            rev[b] = idx[SMP_IDX_W-1-b];
        end
        return rev;
    endfunction
endpackage

// File: rtl/fft_line_mem.sv
// Frame storage: 64 lines of 512 bits, line-wide write, registered 16-bit lane read.
module fft_line_mem
    import fft_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  line_idx_t wr_idx,
    input  line_t     wr_data,
    input  logic      rd_en,
    input  smp_idx_t  rd_idx,
    output sample_t   rd_data
);
    line_t   mem_q [NUM_LINES];
    line_t   rd_line;
    sample_t rd_data_d;
    sample_t rd_data_q;
    logic [LANE_W+LANE_SHIFT-1:0] lane_off;

    // Storage is intentionally not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_line   = mem_q[rd_idx[SMP_IDX_W-1:LANE_W]];
        lane_off  = {rd_idx[LANE_W-1:0], {LANE_SHIFT{1'b0}}};
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_line[lane_off +: SAMPLE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/fft_input_buffer.sv
// Loads a 2048-sample frame line by line, then streams it sample by sample
// in natural or bit-reversed order under a valid/ready handshake.
module fft_input_buffer
    import fft_pkg::*;
#(
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_wr_en,
    input  logic [LINE_IDX_W-1:0] line_index,
    input  logic [LINE_W-1:0]     line_data,
    output logic                  line_ready,
    output logic                  frame_full,
    input  logic                  start,
    output logic                  smp_valid,
    input  logic                  smp_ready,
    output logic [SAMPLE_W-1:0]   smp_data,
    output logic [SMP_IDX_W-1:0]  smp_index,
    output logic                  smp_last,
    output logic                  busy,
    output logic                  done
);
    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   mask_q, mask_d;
    smp_idx_t               cnt_q, cnt_d;
    logic                   smp_valid_q, smp_valid_d;
    smp_idx_t               smp_index_q, smp_index_d;
    logic                   smp_last_q, smp_last_d;
    logic                   done_q, done_d;
    logic                   frame_full_q, frame_full_d;
    logic                   line_ready_q, line_ready_d;
    logic                   busy_q, busy_d;
    logic                   rd_en;
    smp_idx_t               fetch_cnt;
    smp_idx_t               rd_idx;
    logic                   mem_wr_en;

    assign mem_wr_en = line_wr_en && (state_q == ST_LOAD);

    fft_line_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_wr_en),
        .wr_idx  (line_index),
        .wr_data (line_data),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (smp_data)
    );

    // cnt_q tracks the counter value of the sample currently presented.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        smp_valid_d = smp_valid_q;
        smp_index_d = smp_index_q;
        smp_last_d  = smp_last_q;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        fetch_cnt   = cnt_q;

        case (state_q)
            ST_LOAD: begin
                if (line_wr_en) begin
                    mask_d[line_index] = 1'b1;
                end
                if (start && frame_full_q) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!smp_valid_q) begin
                    rd_en       = 1'b1;
                    smp_valid_d = 1'b1;
                end else if (smp_ready) begin
                    if (smp_last_q) begin
                        state_d     = ST_DONE;
                        smp_valid_d = 1'b0;
                        smp_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + SMP_IDX_W'(1);
                        fetch_cnt = cnt_d;
                        rd_en     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                mask_d  = '0;
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        rd_idx = BIT_REVERSE ? bitrev11(fetch_cnt) : fetch_cnt;
        if (rd_en) begin
            smp_index_d = rd_idx;
            smp_last_d  = (fetch_cnt == SMP_IDX_W'(FFT_N - 1));
        end

        frame_full_d = &mask_d;
        line_ready_d = (state_d == ST_LOAD);
        busy_d       = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            mask_q       <= '0;
            cnt_q        <= '0;
            smp_valid_q  <= 1'b0;
            smp_index_q  <= '0;
            smp_last_q   <= 1'b0;
            done_q       <= 1'b0;
            frame_full_q <= 1'b0;
            line_ready_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            smp_valid_q  <= smp_valid_d;
            smp_index_q  <= smp_index_d;
            smp_last_q   <= smp_last_d;
            done_q       <= done_d;
            frame_full_q <= frame_full_d;
            line_ready_q <= line_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign line_ready = line_ready_q;
    assign frame_full = frame_full_q;
    assign smp_valid  = smp_valid_q;
    assign smp_index  = smp_index_q;
    assign smp_last   = smp_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench: a natural-order and a bit-reversed instance share stimulus.
module tb_fft_input_buffer;
    import fft_pkg::*;

    typedef struct packed {
        logic [10:0] idx;
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_wr_en = 1'b0;
    logic [5:0]  line_index = '0;
    line_t       line_data = '0;
    logic        start = 1'b0;
    logic        smp_ready = 1'b1;

    logic        lr_n, ff_n, v_n, l_n, b_n, dn_n;
    logic [15:0] d_n;
    logic [10:0] i_n;
    logic        lr_r, ff_r, v_r, l_r, b_r, dn_r;
    logic [15:0] d_r;
    logic [10:0] i_r;

    logic [15:0] model_mem [FFT_N];
    exp_t        exp_nat [$];
    exp_t        exp_rev [$];
    exp_t        prev_n, prev_r;
    bit          pend_n = 1'b0, pend_r = 1'b0;
    int          n_pass = 0, n_total = 0;
    int          cyc = 0, last_cyc = 0, start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_input_buffer #(.BIT_REVERSE(1'b0)) dut_nat (
        .clk(clk), .rst(rst), .line_wr_en(line_wr_en), .line_index(line_index),
        .line_data(line_data), .line_ready(lr_n), .frame_full(ff_n), .start(start),
        .smp_valid(v_n), .smp_ready(smp_ready), .smp_data(d_n), .smp_index(i_n),
        .smp_last(l_n), .busy(b_n), .done(dn_n));

    fft_input_buffer #(.BIT_REVERSE(1'b1)) dut_rev (
        .clk(clk), .rst(rst), .line_wr_en(line_wr_en), .line_index(line_index),
        .line_data(line_data), .line_ready(lr_r), .frame_full(ff_r), .start(start),
        .smp_valid(v_r), .smp_ready(smp_ready), .smp_data(d_r), .smp_index(i_r),
        .smp_last(l_r), .busy(b_r), .done(dn_r));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [10:0] tb_bitrev(input logic [10:0] x);
        logic [10:0] r;
        for (int b = 0; b < 11; b++) r[10-b] = x[b];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input int l, input line_t d, input bit upd);
        line_wr_en = 1'b1;
        line_index = 6'(l);
        line_data  = d;
        if (upd) for (int k = 0; k < 32; k++) model_mem[32*l+k] = d[16*k +: 16];
        tick();
        line_wr_en = 1'b0;
    endtask

    function automatic line_t nat_line(input int l);
        line_t d;
        for (int k = 0; k < 32; k++) d[16*k +: 16] = 16'(32*l + k);
        return d;
    endfunction

    task automatic load_all();
        for (int l = 0; l < 64; l++) write_line(l, nat_line(l), 1'b1);
    endtask

    // Queue the expected frame for both instances, then pulse start.
    task automatic start_frame();
        logic [10:0] ci, br;
        for (int c = 0; c < FFT_N; c++) begin
            ci = 11'(c);
            br = tb_bitrev(ci);
            exp_nat.push_back({ci, model_mem[ci], c == FFT_N - 1});
            exp_rev.push_back({br, model_mem[br], c == FFT_N - 1});
        end
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        check("valid_low_t1", 32'(v_n), 0);
        check("busy_t1", 32'(b_n), 1);
        check("line_ready_t1", 32'(lr_n), 0);
        tick();
        check("valid_t2_nat", 32'(v_n), 1);
        check("valid_t2_rev", 32'(v_r), 1);
        check("first_idx_nat", 32'(i_n), 0);
        check("first_idx_rev", 32'(i_r), 0);
    endtask

    task automatic wait_done(input int budget, input bit rnd, input bit poke, input bit chk_lat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            smp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && i == 50) begin
                line_wr_en = 1'b1;
                line_index = 6'd5;
                line_data  = '1;
            end else begin
                line_wr_en = 1'b0;
            end
            tick();
            if (dn_n) seen = 1'b1;
        end
        line_wr_en = 1'b0;
        smp_ready  = 1'b1;
        check("done_seen", 32'(seen), 1);
        if (seen) begin
            check("done_rev_aligned", 32'(dn_r), 1);
            check("done_valid_low", 32'(v_n), 0);
            check("done_after_last", 32'(cyc), 32'(last_cyc + 1));
            if (chk_lat) check("done_latency", 32'(cyc - start_cyc), 2050);
            check("queues_drained", 32'(exp_nat.size() + exp_rev.size()), 0);
            tick();
            check("done_one_cycle", 32'(dn_n), 0);
            check("line_ready_back", 32'(lr_n), 1);
            check("mask_cleared", 32'(ff_n), 0);
        end
    endtask

    // Monitor: pop and compare on every transfer, and check hold under backpressure.
    always @(negedge clk) begin
        if (!rst) begin
            if (v_n && pend_n) check("hold_nat", 32'({i_n, d_n, l_n}), 32'(prev_n));
            if (v_r && pend_r) check("hold_rev", 32'({i_r, d_r, l_r}), 32'(prev_r));
            if (v_n && smp_ready) begin
                check("nat_expected", 32'(exp_nat.size() != 0), 1);
                if (exp_nat.size() != 0) check("xfer_nat", 32'({i_n, d_n, l_n}), 32'(exp_nat.pop_front()));
                if (l_n) last_cyc = cyc;
            end
            if (v_r && smp_ready) begin
                check("rev_expected", 32'(exp_rev.size() != 0), 1);
                if (exp_rev.size() != 0) check("xfer_rev", 32'({i_r, d_r, l_r}), 32'(exp_rev.pop_front()));
            end
        end
        pend_n = v_n && !smp_ready && !rst;
        pend_r = v_r && !smp_ready && !rst;
        prev_n = {i_n, d_n, l_n};
        prev_r = {i_r, d_r, l_r};
    end

    initial begin
        bit saw_valid;
        bit seen;
        tick();
        tick();
        rst = 1'b0;
        check("rst_line_ready", 32'(lr_n), 1);
        check("rst_outputs_nat", 32'({ff_n, v_n, l_n, b_n, dn_n, d_n, i_n}), 0);
        check("rst_outputs_rev", 32'({ff_r, v_r, l_r, b_r, dn_r, lr_r}), 1);

        // Natural and bit-reversed streaming with ready high.
        for (int l = 0; l < 63; l++) write_line(l, nat_line(l), 1'b1);
        check("ff_after_63", 32'(ff_n), 0);
        write_line(63, nat_line(63), 1'b1);
        check("ff_after_64", 32'(ff_n), 1);
        start_frame();
        tick();
        check("idx1_nat", 32'(i_n), 1);
        check("idx1_rev", 32'(i_r), 1024);
        tick();
        check("idx2_nat", 32'(i_n), 2);
        check("idx2_rev", 32'(i_r), 512);
        tick();
        check("idx3_nat", 32'(i_n), 3);
        check("idx3_rev", 32'(i_r), 1536);
        wait_done(2100, 1'b0, 1'b0, 1'b1);

        // Incomplete frame: start ignored until the 64th line is written.
        for (int l = 0; l < 63; l++) write_line(l, nat_line(l), 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (v_n || v_r) saw_valid = 1'b1;
        end
        check("no_valid_partial", 32'(saw_valid), 0);
        check("ff_partial", 32'(ff_n), 0);
        start = 1'b1;
        write_line(63, nat_line(63), 1'b1);
        start = 1'b0;
        check("start_with_write_ignored", 32'(b_n), 0);
        check("ff_after_write", 32'(ff_n), 1);
        start_frame();
        wait_done(2100, 1'b0, 1'b0, 1'b1);

        // Random backpressure plus an ignored write during STREAM.
        load_all();
        start_frame();
        wait_done(10000, 1'b1, 1'b1, 1'b0);

        // Line rewrite: second write wins, full only after all distinct lines.
        write_line(3, {32{16'hAAAA}}, 1'b1);
        write_line(3, {32{16'h5555}}, 1'b1);
        check("ff_after_rewrite", 32'(ff_n), 0);
        for (int l = 0; l < 64; l++) begin
            if (l == 63) check("ff_before_last", 32'(ff_n), 0);
            if (l != 3) write_line(l, nat_line(l), 1'b1);
        end
        check("ff_rewrite_full", 32'(ff_n), 1);
        start_frame();
        wait_done(2100, 1'b0, 1'b0, 1'b1);

        // Reset at sample 700 aborts the frame.
        load_all();
        start_frame();
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (v_n && i_n == 11'd700) seen = 1'b1;
            else tick();
        end
        check("reach_700", 32'(seen), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_nat.delete();
        exp_rev.delete();
        check("abort_valid", 32'(v_n), 0);
        check("abort_busy", 32'(b_n), 0);
        check("abort_line_ready", 32'(lr_n), 1);
        check("abort_frame_full", 32'(ff_n), 0);
        load_all();
        start_frame();
        wait_done(2100, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
